// File: rtl/channel_4_noise_generator_if.sv
// Channel-4 noise generator bus: sample strobe, sequencer controls and sample output.
// The sequencer side is the master; the noise generator is the slave.
interface channel_4_noise_generator_if;
    logic        i_sample_stb;
    logic [31:0] i_phase_delta;
    logic [8:0]  i_envelope;
    logic        i_mode;
    logic [8:0]  o_sample;
    logic        o_sample_valid;

    modport master (
        output i_sample_stb,
        output i_phase_delta,
        output i_envelope,
        output i_mode,
        input  o_sample,
        input  o_sample_valid
    );

    modport slave (
        input  i_sample_stb,
        input  i_phase_delta,
        input  i_envelope,
        input  i_mode,
        output o_sample,
        output o_sample_valid
    );
endinterface

// File: rtl/channel_4_noise_generator.sv
// Channel-4 noise voice: phase accumulator whose carry clocks a 15-bit LFSR,
// with the LFSR low bit gating the envelope into a registered sample.
module channel_4_noise_generator #(
    parameter logic [14:0] LFSR_SEED = 15'h0001
) (
    input logic                          i_clk,
    input logic                          i_rst,
    channel_4_noise_generator_if.slave   ch4_bus
);
    // An all-zero LFSR would lock up, so a zero seed falls back to 1.
    localparam logic [14:0] SEED = (LFSR_SEED == 15'd0) ? 15'h0001 : LFSR_SEED;

    logic [31:0] r_acc;
    logic [14:0] r_lfsr;
    logic [8:0]  r_sample;
    logic        r_valid;

    logic [32:0] w_sum;
    logic        w_fb;
    logic [14:0] w_lfsr_next;

    assign w_sum       = {1'b0, r_acc} + {1'b0, ch4_bus.i_phase_delta};
    assign w_fb        = r_lfsr[0] ^ (ch4_bus.i_mode ? r_lfsr[6] : r_lfsr[1]);
    assign w_lfsr_next = w_sum[32] ? {w_fb, r_lfsr[14:1]} : r_lfsr;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc    <= 32'd0;
            r_lfsr   <= SEED;
            r_sample <= 9'd0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= ch4_bus.i_sample_stb;
            if (ch4_bus.i_sample_stb) begin
                r_acc    <= w_sum[31:0];
                r_lfsr   <= w_lfsr_next;
                r_sample <= w_lfsr_next[0] ? 9'd0 : ch4_bus.i_envelope;
            end
        end
    end

    assign ch4_bus.o_sample       = r_sample;
    assign ch4_bus.o_sample_valid = r_valid;
endmodule

// File: tb/tb_channel_4_noise_generator.sv
// Directed-vector bench for the channel-4 noise generator, with a small
// reference model for the long period, mode-1 and random-run sequences.
module tb_channel_4_noise_generator;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    channel_4_noise_generator_if bus ();
    channel_4_noise_generator_if bus0 ();

    channel_4_noise_generator dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .ch4_bus (bus)
    );

    channel_4_noise_generator #(.LFSR_SEED(15'h0000)) dut0 (
        .i_clk   (clk),
        .i_rst   (rst),
        .ch4_bus (bus0)
    );

    typedef struct {
        logic        stb;
        logic [31:0] delta;
        logic [8:0]  env;
        logic        mode;
        logic        exp_valid;
        logic [8:0]  exp_sample;
        logic [14:0] exp_lfsr;
    } vec_t;

    vec_t tbl[9];

    int checks = 0;
    int fails  = 0;

    logic [31:0] m_acc;
    logic [14:0] m_lfsr;
    logic [8:0]  m_sample;
    logic        m_valid;
    int          m_shifts;

    function automatic logic [14:0] nxt(input logic [14:0] v, input logic md);
        logic fb;
        fb = v[0] ^ (md ? v[6] : v[1]);
        return {fb, v[14:1]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic stb, input logic [31:0] delta,
                         input logic [8:0] env, input logic mode);
        bus.i_sample_stb  = stb;
        bus.i_phase_delta = delta;
        bus.i_envelope    = env;
        bus.i_mode        = mode;
    endtask

    task automatic tick();
        logic [32:0] s;
        @(posedge clk);
        if (rst) begin
            m_acc    = 32'd0;
            m_lfsr   = 15'h0001;
            m_sample = 9'd0;
            m_valid  = 1'b0;
        end else begin
            m_valid = bus.i_sample_stb;
            if (bus.i_sample_stb) begin
                s     = {1'b0, m_acc} + {1'b0, bus.i_phase_delta};
                m_acc = s[31:0];
                if (s[32]) begin
                    m_lfsr = nxt(m_lfsr, bus.i_mode);
                    m_shifts++;
                end
                m_sample = m_lfsr[0] ? 9'd0 : bus.i_envelope;
            end
        end
        #1;
    endtask

    task automatic run_vec(input int i, input string tag);
        drive(tbl[i].stb, tbl[i].delta, tbl[i].env, tbl[i].mode);
        tick();
        chk($sformatf("%s%0d_valid", tag, i), 32'(bus.o_sample_valid),
            32'(tbl[i].exp_valid));
        chk($sformatf("%s%0d_sample", tag, i), 32'(bus.o_sample),
            32'(tbl[i].exp_sample));
        chk($sformatf("%s%0d_lfsr", tag, i), 32'(dut.r_lfsr),
            32'(tbl[i].exp_lfsr));
    endtask

    initial begin
        int mism;
        int cnt;
        int ret;
        logic [8:0] held;

        tbl[0] = '{1'b1, 32'h8000_0000, 9'd20, 1'b0, 1'b1, 9'd0,  15'h0001};
        tbl[1] = '{1'b1, 32'h8000_0000, 9'd20, 1'b0, 1'b1, 9'd20, 15'h4000};
        tbl[2] = '{1'b0, 32'h8000_0000, 9'd12, 1'b0, 1'b0, 9'd20, 15'h4000};
        tbl[3] = '{1'b0, 32'hFFFF_FFFF, 9'd12, 1'b1, 1'b0, 9'd20, 15'h4000};
        tbl[4] = '{1'b1, 32'h8000_0000, 9'd12, 1'b1, 1'b1, 9'd12, 15'h4000};
        tbl[5] = '{1'b1, 32'h8000_0000, 9'd0,  1'b1, 1'b1, 9'd0,  15'h2000};
        tbl[6] = '{1'b1, 32'hFFFF_FFFF, 9'd7,  1'b1, 1'b1, 9'd7,  15'h2000};
        tbl[7] = '{1'b1, 32'h0000_0001, 9'd7,  1'b0, 1'b1, 9'd7,  15'h1000};
        tbl[8] = '{1'b0, 32'h0000_0001, 9'd99, 1'b0, 1'b0, 9'd7,  15'h1000};

        bus0.i_sample_stb  = 1'b0;
        bus0.i_phase_delta = 32'd0;
        bus0.i_envelope    = 9'd0;
        bus0.i_mode        = 1'b0;
        m_shifts = 0;

        // Reset with strobes pulsing
        rst = 1'b1;
        drive(1'b1, 32'hFFFF_FFFF, 9'd33, 1'b0);
        tick();
        drive(1'b0, 32'hFFFF_FFFF, 9'd33, 1'b0);
        tick();
        chk("rst_valid", 32'(bus.o_sample_valid), 32'd0);
        chk("rst_sample", 32'(bus.o_sample), 32'd0);
        chk("rst_acc", dut.r_acc, 32'd0);
        chk("rst_lfsr", 32'(dut.r_lfsr), 32'h0001);
        chk("seed0_lfsr", 32'(dut0.r_lfsr), 32'h0001);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(i, "vec");
        chk("vec_acc", dut.r_acc, 32'd0);

        // Zero delta: no shifts, sample constant
        cnt = 0;
        mism = 0;
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, 32'd0, 9'd5, i[0]);
            tick();
            if (bus.o_sample_valid === 1'b1) cnt++;
            if (bus.o_sample !== 9'd5) mism++;
        end
        chk("zd_valid_count", 32'(cnt), 32'd100);
        chk("zd_sample_mism", 32'(mism), 32'd0);
        chk("zd_lfsr", 32'(dut.r_lfsr), 32'h1000);

        // Envelope zero with shifting active
        mism = 0;
        for (int i = 0; i < 50; i++) begin
            drive(1'b1, 32'hFFFF_FFFF, 9'd0, 1'b0);
            tick();
            if (bus.o_sample !== 9'd0 || bus.o_sample_valid !== 1'b1) mism++;
        end
        chk("gate_zero_mism", 32'(mism), 32'd0);
        chk("gate_lfsr", 32'(dut.r_lfsr), 32'(m_lfsr));
        chk("gate_shifted", 32'(m_lfsr != 15'h1000), 32'd1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'hFFFF_FFFF, 9'd12, 1'b0);
            tick();
            chk($sformatf("gate_hold%0d", i), 32'(bus.o_sample), 32'd0);
        end
        drive(1'b1, 32'h0000_0000, 9'd12, 1'b0);
        tick();
        chk("gate_env12", 32'(bus.o_sample), 32'(m_sample));
        chk("gate_env12_nz", 32'(bus.o_sample), 32'(m_lfsr[0] ? 9'd0 : 9'd12));

        // Period of mode 0
        rst = 1'b1;
        drive(1'b0, 32'd0, 9'd0, 1'b0);
        tick();
        rst = 1'b0;
        m_shifts = 0;
        mism = 0;
        ret = 0;
        for (int i = 0; i < 33000 && ret == 0; i++) begin
            drive(1'b1, 32'hFFFF_FFFF, 9'd3, 1'b0);
            tick();
            if (dut.r_lfsr !== m_lfsr) mism++;
            if (m_shifts > 0 && dut.r_lfsr === 15'h0001) ret = m_shifts;
        end
        chk("period_shifts", 32'(ret), 32'd32767);
        chk("period_track", 32'(mism), 32'd0);

        // Mode 1 against the model
        mism = 0;
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 32'hFFFF_FFFF, 9'(i + 1), 1'b1);
            tick();
            if (dut.r_lfsr !== m_lfsr || bus.o_sample !== m_sample) mism++;
        end
        chk("mode1_mism", 32'(mism), 32'd0);

        // Random run, then reset coincident with a strobe
        mism = 0;
        for (int i = 0; i < 1000; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom,
                  9'($urandom_range(0, 511)), 1'($urandom_range(0, 1)));
            tick();
            if (bus.o_sample !== m_sample ||
                bus.o_sample_valid !== m_valid) mism++;
        end
        chk("rand_mism", 32'(mism), 32'd0);
        held = bus.o_sample;
        rst = 1'b1;
        drive(1'b1, 32'h8000_0000, 9'd20, 1'b0);
        tick();
        chk("midrst_valid", 32'(bus.o_sample_valid), 32'd0);
        chk("midrst_sample", 32'(bus.o_sample), 32'd0);
        chk("midrst_acc", dut.r_acc, 32'd0);
        chk("midrst_lfsr", 32'(dut.r_lfsr), 32'h0001);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) run_vec(i, "replay");

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
